// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Single-issue RV32I integer-ALU control. Accepts one instruction
//            at a time, decodes it into ALU controls and register indices,
//            holds it for one ALU cycle and retires it with write-back,
//            redirect and done strobes. Unsupported encodings are rejected
//            with a one-cycle illegal strobe.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            instr_valid/ready     - upstream handshake (ready only when idle)
//            instruction[31:0]     - RV32I instruction word
//            ALU_Control[5:0], branch_op, op_b_imm, imm[31:0],
//            rs1, rs2, rd          - registered decode results (held)
//            alu_valid             - ALU operands/controls meaningful
//            branch                - ALU branch result, sampled end of EXEC
//            reg_write, take_branch, illegal, done - one-cycle strobes
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  output logic [5:0]  ALU_Control,
  output logic        branch_op,
  output logic        op_b_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        alu_valid,
  input  logic        branch,
  output logic        reg_write,
  output logic        take_branch,
  output logic        illegal,
  output logic        done
);

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_B    = 7'b1100011;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  localparam logic [5:0] c_ALU_SUB  = 6'b001000;
  localparam logic [5:0] c_ALU_SRA  = 6'b001101;
  localparam logic [5:0] c_ALU_JUMP = 6'b111111;
  localparam logic [5:0] c_ALU_LUI  = 6'b011111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_instr;
  logic        r_illegal;
  logic        r_wb_en;
  logic        r_is_jump;
  logic        r_branch_res;

  // Instruction fields of the latched word
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_sh;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];
  assign w_funct7 = r_instr[31:25];
  assign w_imm_i  = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_sh = {27'd0, r_instr[24:20]};
  assign w_imm_b  = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                     r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_j  = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                     r_instr[20], r_instr[30:21], 1'b0};
  assign w_imm_u  = {r_instr[31:12], 12'd0};

  // Decoder outputs
  logic        w_legal;
  logic [5:0]  w_alu;
  logic        w_bop;
  logic        w_obi;
  logic [31:0] w_imm;
  logic        w_writes;
  logic        w_is_jump;
  logic        w_wb_en;
  logic        w_is_shift;

  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    w_legal   = 1'b0;
    w_alu     = 6'd0;
    w_bop     = 1'b0;
    w_obi     = 1'b0;
    w_imm     = 32'd0;
    w_writes  = 1'b0;
    w_is_jump = 1'b0;
    case (w_opcode)
      c_OP_R: begin
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
        w_legal  = (w_funct7 == c_F7_BASE) ||
                   ((w_funct7 == c_F7_ALT) &&
                    ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        w_writes = 1'b1;
        if (w_funct7 == c_F7_ALT)
          w_alu = (w_funct3 == 3'b000) ? c_ALU_SUB : c_ALU_SRA;
        else
          w_alu = {3'b000, w_funct3};
      end
      c_OP_I: begin
        // funct7 only matters for shifts; SLLI has no alternate form
        if (w_funct3 == 3'b001)
          w_legal = (w_funct7 == c_F7_BASE);
        else if (w_funct3 == 3'b101)
          w_legal = (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT);
        else
          w_legal = 1'b1;
        w_obi    = 1'b1;
        w_writes = 1'b1;
        w_imm    = w_is_shift ? w_imm_sh : w_imm_i;
        if ((w_funct3 == 3'b101) && (w_funct7 == c_F7_ALT))
          w_alu = c_ALU_SRA;
        else
          w_alu = {3'b000, w_funct3};
      end
      c_OP_B: begin
        w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_alu   = {3'b010, w_funct3};
        w_bop   = 1'b1;
        w_imm   = w_imm_b;
      end
      c_OP_JALR: begin
        w_legal   = (w_funct3 == 3'b000);
        w_alu     = c_ALU_JUMP;
        w_obi     = 1'b1;
        w_imm     = w_imm_i;
        w_writes  = 1'b1;
        w_is_jump = 1'b1;
      end
      c_OP_JAL: begin
        w_legal   = 1'b1;
        w_alu     = c_ALU_JUMP;
        w_imm     = w_imm_j;
        w_writes  = 1'b1;
        w_is_jump = 1'b1;
      end
      c_OP_LUI: begin
        w_legal  = 1'b1;
        w_alu    = c_ALU_LUI;
        w_obi    = 1'b1;
        w_imm    = w_imm_u;
        w_writes = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Writes to x0 are architecturally discarded, so no strobe is issued
  assign w_wb_en = w_writes && (r_instr[11:7] != 5'd0);

  // While the illegal strobe is out the FSM already sits in IDLE, but the
  // block is not ready until the cycle after, keeping the reject latency fixed.
  assign instr_ready = (r_state == S_IDLE) && !r_illegal;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid && instr_ready) w_state_next = S_DECODE;
      S_DECODE: w_state_next = w_legal ? S_EXEC : S_IDLE;
      S_EXEC:   w_state_next = S_WB;
      S_WB:     w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr      <= 32'd0;
      r_illegal    <= 1'b0;
      r_wb_en      <= 1'b0;
      r_is_jump    <= 1'b0;
      r_branch_res <= 1'b0;
      ALU_Control  <= 6'd0;
      branch_op    <= 1'b0;
      op_b_imm     <= 1'b0;
      imm          <= 32'd0;
      rs1          <= 5'd0;
      rs2          <= 5'd0;
      rd           <= 5'd0;
    end else begin
      r_illegal <= (r_state == S_DECODE) && !w_legal;
      if ((r_state == S_IDLE) && instr_ready && instr_valid)
        r_instr <= instruction;
      // Rejected instructions leave the previous decode visible
      if ((r_state == S_DECODE) && w_legal) begin
        ALU_Control <= w_alu;
        branch_op   <= w_bop;
        op_b_imm    <= w_obi;
        imm         <= w_imm;
        rs1         <= r_instr[19:15];
        rs2         <= r_instr[24:20];
        rd          <= r_instr[11:7];
        r_wb_en     <= w_wb_en;
        r_is_jump   <= w_is_jump;
      end
      if (r_state == S_EXEC)
        r_branch_res <= branch;
    end
  end

  assign alu_valid   = (r_state == S_EXEC);
  assign done        = (r_state == S_WB);
  assign reg_write   = (r_state == S_WB) && r_wb_en;
  assign take_branch = (r_state == S_WB) && (r_is_jump || (branch_op && r_branch_res));
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. Directed cases, illegal
//            encodings, reset behaviour and randomized instructions checked
//            against a behavioural decode model of the RV32I subset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        branch;
  logic        instr_ready;
  logic [5:0]  ALU_Control;
  logic        branch_op;
  logic        op_b_imm;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_valid, reg_write, take_branch, illegal, done;

  alu_issue_ctrl dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instruction(instruction), .instr_ready(instr_ready),
    .ALU_Control(ALU_Control), .branch_op(branch_op), .op_b_imm(op_b_imm),
    .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_valid(alu_valid),
    .branch(branch), .reg_write(reg_write), .take_branch(take_branch),
    .illegal(illegal), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        legal;
    logic [5:0]  alu;
    logic        bop;
    logic        obi;
    logic [31:0] imm;
    logic        wb;
    logic        jmp;
  } exp_t;

  // Reference decode written from the ISA rules
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    e = '0;
    case (op)
      7'h33: begin
        e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu   = (f7 == 7'h20) ? ((f3 == 3'd0) ? 6'd8 : 6'd13) : {3'd0, f3};
        e.wb    = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd1)      e.legal = (f7 == 7'h00);
        else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 e.legal = 1'b1;
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 6'd13 : {3'd0, f3};
        e.obi = 1'b1;
        e.wb  = 1'b1;
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      end
      7'h63: begin
        e.legal = (f3 != 3'd2) && (f3 != 3'd3);
        e.alu   = {3'b010, f3};
        e.bop   = 1'b1;
        e.imm   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'h67: begin
        e.legal = (f3 == 3'd0);
        e.alu   = 6'h3F;
        e.obi   = 1'b1;
        e.imm   = {{20{w[31]}}, w[31:20]};
        e.wb    = 1'b1;
        e.jmp   = 1'b1;
      end
      7'h6F: begin
        e.legal = 1'b1;
        e.alu   = 6'h3F;
        e.imm   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e.wb    = 1'b1;
        e.jmp   = 1'b1;
      end
      7'h37: begin
        e.legal = 1'b1;
        e.alu   = 6'h1F;
        e.obi   = 1'b1;
        e.imm   = {w[31:12], 12'd0};
        e.wb    = 1'b1;
      end
      default: e.legal = 1'b0;
    endcase
    if (w[11:7] == 5'd0) e.wb = 1'b0;
    return e;
  endfunction

  // Observations from one issued instruction (cycle index k relative to accept)
  int          first_alu, n_alu, first_done, n_done, first_rw, n_rw;
  int          first_tb, n_tb, first_ill, n_ill, first_rdy;
  logic [54:0] p_dec, s_dec, h_dec;
  logic        issued;

  // Drives one instruction and records what the DUT did; no judgement here.
  task automatic drive_instr(input logic [31:0] w, input logic br);
    int guard;
    first_alu = 0; n_alu = 0; first_done = 0; n_done = 0; first_rw = 0; n_rw = 0;
    first_tb = 0; n_tb = 0; first_ill = 0; n_ill = 0; first_rdy = 0;
    issued = 1'b0;
    guard = 0;
    @(negedge clock);
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (instr_ready !== 1'b1) return;
    issued      = 1'b1;
    p_dec       = {ALU_Control, branch_op, op_b_imm, imm, rs1, rs2, rd};
    instr_valid = 1'b1;
    instruction = w;
    branch      = ~br;
    @(posedge clock);
    #1;
    instruction = $urandom;  // must be ignored outside IDLE
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (alu_valid === 1'b1)   begin n_alu++;  if (first_alu == 0)  first_alu = k;  end
      if (done === 1'b1)        begin n_done++; if (first_done == 0) first_done = k; end
      if (reg_write === 1'b1)   begin n_rw++;   if (first_rw == 0)   first_rw = k;   end
      if (take_branch === 1'b1) begin n_tb++;   if (first_tb == 0)   first_tb = k;   end
      if (illegal === 1'b1)     begin n_ill++;  if (first_ill == 0)  first_ill = k;  end
      if (instr_ready === 1'b1 && first_rdy == 0) first_rdy = k;
      if (k == 2) s_dec = {ALU_Control, branch_op, op_b_imm, imm, rs1, rs2, rd};
      if (k == 5) h_dec = {ALU_Control, branch_op, op_b_imm, imm, rs1, rs2, rd};
      branch      = (k == 2) ? br : ~br;
      instr_valid = (k <= 2);
      instruction = $urandom;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b1; instruction = 32'h002081B3; branch = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({ALU_Control, branch_op, op_b_imm, imm, rs1, rs2, rd,
         alu_valid, reg_write, take_branch, illegal, done} !== 62'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {ALU_Control, imm, rs1, rs2, rd});
    end
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b1 || alu_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b alu_valid=%b done=%b want 1 0 0",
               instr_ready, alu_valid, done);
    end
  endtask

  typedef struct {
    logic [31:0] w;
    logic        br;
    logic [5:0]  alu;
    logic        bop;
    logic        obi;
    logic [31:0] imm;
    logic        rw;
    logic        tk;
    logic [4:0]  rd;
  } dcase_t;

  task automatic test_directed();
    dcase_t dc[7];
    dc[0] = '{32'h002081B3, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd3}; // ADD
    dc[1] = '{32'h402081B3, 1'b1, 6'b001000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd3}; // SUB
    dc[2] = '{32'h4042D293, 1'b0, 6'b001101, 1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 5'd5}; // SRAI
    dc[3] = '{32'h00208463, 1'b1, 6'b010000, 1'b1, 1'b0, 32'h8,        1'b0, 1'b1, 5'd8}; // BEQ taken
    dc[4] = '{32'h00208463, 1'b0, 6'b010000, 1'b1, 1'b0, 32'h8,        1'b0, 1'b0, 5'd8}; // BEQ not
    dc[5] = '{32'hFCE100E7, 1'b0, 6'b111111, 1'b0, 1'b1, 32'hFFFFFFCE, 1'b1, 1'b1, 5'd1}; // JALR
    dc[6] = '{32'h00208033, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0}; // ADD x0
    for (int i = 0; i < 7; i++) begin
      drive_instr(dc[i].w, dc[i].br);
      n_cmp++;
      if (!issued || first_alu != 2 || n_alu != 1 || first_done != 3 || n_done != 1 ||
          first_rdy != 4 || n_ill != 0) begin
        n_fail++;
        $display("FAIL dir_timing[%0d] %h: alu@%0d x%0d done@%0d x%0d rdy@%0d ill=%0d want 2 1 3 1 4 0",
                 i, dc[i].w, first_alu, n_alu, first_done, n_done, first_rdy, n_ill);
      end
      n_cmp++;
      if (s_dec[54:15] !== {dc[i].alu, dc[i].bop, dc[i].obi, dc[i].imm} ||
          s_dec[4:0] !== dc[i].rd) begin
        n_fail++;
        $display("FAIL dir_decode[%0d] %h: got %h want %h rd=%0d", i, dc[i].w,
                 s_dec[54:15], {dc[i].alu, dc[i].bop, dc[i].obi, dc[i].imm}, dc[i].rd);
      end
      n_cmp++;
      if ((n_rw != 0) !== dc[i].rw || (n_tb != 0) !== dc[i].tk ||
          (dc[i].rw && first_rw != 3) || (dc[i].tk && first_tb != 3)) begin
        n_fail++;
        $display("FAIL dir_strobes[%0d] %h: rw=%0d@%0d tb=%0d@%0d want rw=%b tb=%b at 3",
                 i, dc[i].w, n_rw, first_rw, n_tb, first_tb, dc[i].rw, dc[i].tk);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad[5];
    bad[0] = 32'h0000A183;  // load opcode
    bad[1] = 32'h202081B3;  // R with unknown funct7
    bad[2] = 32'h0020A463;  // B funct3 010
    bad[3] = 32'hFCE110E7;  // JALR funct3 001
    bad[4] = 32'h40429293;  // SLLI with alternate funct7
    for (int i = 0; i < 5; i++) begin
      drive_instr(bad[i], 1'b1);
      n_cmp++;
      if (!issued || first_ill != 2 || n_ill != 1 || first_rdy != 3) begin
        n_fail++;
        $display("FAIL ill_timing %h: ill@%0d x%0d rdy@%0d want 2 1 3",
                 bad[i], first_ill, n_ill, first_rdy);
      end
      n_cmp++;
      if (n_alu != 0 || n_done != 0 || n_rw != 0 || n_tb != 0) begin
        n_fail++;
        $display("FAIL ill_strobes %h: alu=%0d done=%0d rw=%0d tb=%0d want 0",
                 bad[i], n_alu, n_done, n_rw, n_tb);
      end
      n_cmp++;
      if (h_dec !== p_dec) begin
        n_fail++;
        $display("FAIL ill_hold %h: got %h want %h", bad[i], h_dec, p_dec);
      end
    end
  endtask

  task automatic test_reset_exec();
    int guard;
    int strobes;
    guard = 0;
    @(negedge clock);
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    instr_valid = 1'b1;
    instruction = 32'h002081B3;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (alu_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_exec_pre: alu_valid=%b want 1", alu_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({ALU_Control, branch_op, op_b_imm, imm, rs1, rs2, rd,
         alu_valid, reg_write, take_branch, illegal, done} !== 62'd0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_exec_outputs: done=%b rw=%b rd=%0d ready=%b want 0 0 0 1",
               done, reg_write, rd, instr_ready);
    end
    reset = 1'b0;
    strobes = 0;
    repeat (3) begin
      @(negedge clock);
      if (done === 1'b1 || reg_write === 1'b1 || alu_valid === 1'b1) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL rst_exec_abort: strobe cycles=%0d want 0", strobes);
    end
    drive_instr(32'h002081B3, 1'b0);
    n_cmp++;
    if (!issued || first_done != 3 || first_rw != 3 || s_dec[4:0] !== 5'd3) begin
      n_fail++;
      $display("FAIL rst_exec_next: done@%0d rw@%0d rd=%0d want 3 3 3",
               first_done, first_rw, s_dec[4:0]);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops[8];
    logic [31:0] w;
    logic        br;
    exp_t        e;
    int          sel;
    logic        tk;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h63; ops[3] = 7'h67;
    ops[4] = 7'h6F; ops[5] = 7'h37; ops[6] = 7'h03;
    for (int i = 0; i < 60; i++) begin
      ops[7] = 7'($urandom);
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 7)];
      sel = $urandom_range(0, 3);
      if (sel == 0) w[31:25] = 7'h00;
      else if (sel == 1) w[31:25] = 7'h20;
      if ($urandom_range(0, 3) == 0) w[14:12] = 3'd0;
      br = 1'($urandom);
      e  = model(w);
      tk = e.jmp || (e.bop && br);
      drive_instr(w, br);
      if (e.legal) begin
        n_cmp++;
        if (!issued || first_alu != 2 || n_alu != 1 || first_done != 3 || n_done != 1 ||
            first_rdy != 4 || n_ill != 0) begin
          n_fail++;
          $display("FAIL rnd_timing %h: alu@%0d x%0d done@%0d x%0d rdy@%0d ill=%0d want 2 1 3 1 4 0",
                   w, first_alu, n_alu, first_done, n_done, first_rdy, n_ill);
        end
        n_cmp++;
        if (s_dec !== {e.alu, e.bop, e.obi, e.imm, w[19:15], w[24:20], w[11:7]} || h_dec !== s_dec) begin
          n_fail++;
          $display("FAIL rnd_decode %h: got %h held %h want %h", w, s_dec, h_dec,
                   {e.alu, e.bop, e.obi, e.imm, w[19:15], w[24:20], w[11:7]});
        end
        n_cmp++;
        if ((n_rw != 0) !== e.wb || (n_tb != 0) !== tk || n_rw > 1 || n_tb > 1 ||
            (e.wb && first_rw != 3) || (tk && first_tb != 3)) begin
          n_fail++;
          $display("FAIL rnd_strobes %h br=%b: rw=%0d@%0d tb=%0d@%0d want rw=%b tb=%b",
                   w, br, n_rw, first_rw, n_tb, first_tb, e.wb, tk);
        end
      end else begin
        n_cmp++;
        if (!issued || first_ill != 2 || n_ill != 1 || first_rdy != 3 ||
            n_alu != 0 || n_done != 0 || n_rw != 0 || n_tb != 0 || h_dec !== p_dec) begin
          n_fail++;
          $display("FAIL rnd_illegal %h: ill@%0d x%0d rdy@%0d alu=%0d done=%0d want 2 1 3 0 0",
                   w, first_ill, n_ill, first_rdy, n_alu, n_done);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = 32'd0; branch = 1'b0;
    test_reset();
    test_directed();
    test_illegal();
    test_reset_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: instr_valid  input  1  upstream fetch presents instruction.
REQ-004 SHALL have port: instruction  input  32  RV32I instruction word.
REQ-005 SHALL have port: instr_ready  output  1  block can accept an instruction.
REQ-006 SHALL have port: ALU_Control  output  6  ALU operation code.
REQ-007 SHALL have port: branch_op  output  1  ALU evaluates branch condition.
REQ-008 SHALL have port: op_b_imm  output  1  1 = operand_B from imm, 0 = from rs2.
REQ-009 SHALL have port: imm  output  32  decoded immediate.
REQ-010 SHALL have port: rs1, rs2, rd  output  5 each  register indices.
REQ-011 SHALL have port: alu_valid  output  1  ALU outputs meaningful this cycle.
REQ-012 SHALL have port: branch  input  1  ALU branch result, valid when alu_valid.
REQ-013 SHALL have port: reg_write  output  1  one-cycle write-back strobe.
REQ-014 SHALL have port: take_branch  output  1  one-cycle redirect strobe.
REQ-015 SHALL have port: illegal  output  1  one-cycle unsupported-instruction strobe.
REQ-016 SHALL have port: done  output  1  one-cycle instruction-retired strobe.

Function
REQ-017 SHALL implement FSM states IDLE, DECODE, EXEC, WB; instr_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE with instr_valid=1, latch instruction and enter DECODE; otherwise remain in IDLE; instruction is ignored outside IDLE.
REQ-019 SHALL in DECODE register ALU_Control, branch_op, op_b_imm, imm, rs1/rs2/rd, then enter EXEC; illegal instruction instead pulses illegal in the next cycle and returns to IDLE without alu_valid, reg_write or done.
REQ-020 SHALL assert alu_valid for exactly the EXEC cycle, sample branch at its end, then enter WB.
REQ-021 SHALL in WB pulse done; pulse reg_write for R, I-ALU, JAL, JALR, LUI with rd!=0; pulse take_branch for JAL, JALR, or B-type with sampled branch=1; then return to IDLE.
REQ-022 SHALL give latency: accept at edge N, alu_valid cycle N+2, done cycle N+3, instr_ready again cycle N+4.
REQ-023 SHALL encode ALU_Control: R/I-ALU {3'b000,funct3}; SUB 6'b001000 (R only); SRA/SRAI 6'b001101; B-type {3'b010,funct3}; JAL, JALR 6'b111111; LUI 6'b011111.
REQ-024 SHALL set branch_op=1 only for B-type; op_b_imm=1 for I-ALU, JALR, LUI; 0 otherwise.
REQ-025 SHALL form imm: I-type sign-extended inst[31:20]; shifts zero-extended inst[24:20]; B, J, U per RV32I, B/J sign-extended with bit 0 = 0, U low 12 bits zero; R-type imm = 0.
REQ-026 SHALL treat as illegal: opcodes other than 0110011, 0010011, 1100011, 1100111, 1101111, 0110111; R funct7 other than 0000000, or 0100000 only with funct3 000/101; I shift funct7 rules likewise (0100000 only with 101; never with 001); B funct3 010/011; JALR funct3!=000.
REQ-027 SHALL hold ALU_Control, branch_op, op_b_imm, imm, rs1/rs2/rd at last decoded values until next DECODE.

Reset
REQ-028 SHALL on reset force state IDLE; ALU_Control=0, branch_op=0, op_b_imm=0, imm=0, rs1=rs2=rd=0, alu_valid=0, reg_write=0, take_branch=0, illegal=0, done=0; instr_ready=1 the cycle after reset deasserts.
REQ-029 SHALL, on reset in any state, abort the in-flight instruction with no further strobes.
REQ-030 SHALL let reset dominate instr_valid in the same cycle.

Verification
REQ-031 SHALL pass: ADD x3,x1,x2 (0x002081B3) -> ALU_Control=000000, op_b_imm=0, done at N+3, reg_write=1, rd=3.
REQ-032 SHALL pass: SUB (0x402081B3) -> 001000; SRAI x5,x5,4 (0x4042D293) -> 001101, imm=4.
REQ-033 SHALL pass: BEQ with branch=1 -> ALU_Control=010000, branch_op=1, take_branch=1, reg_write=0; same with branch=0 -> take_branch=0.
REQ-034 SHALL pass: JALR x1,-50(x2) -> 111111, imm=0xFFFFFFCE, reg_write=1, take_branch=1.
REQ-035 SHALL pass: opcode 0000011 (load) -> illegal pulse at N+2, no done, instr_ready at N+3.
REQ-036 SHALL pass: reset asserted during EXEC -> no done/reg_write, all outputs at reset values, next instruction accepted normally.
